seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the team's 32-bit combinational ALU. It keeps the AND/OR/ADD/SUB/SLT operations and their flag semantics. It adds XOR, NOR, and an iterative unsigned multiply and divide that take DATA_WIDTH cycles each. It sits between the decode stage and writeback as a single-issue execution unit with valid/ready on both sides.

## Interface
- DATA_WIDTH, 32: operand/result width, ≥4 (need not be a power of two).
- CNT_W, $clog2(DATA_WIDTH+1): iteration counter width (derived, do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; equals (state==IDLE).
- A  in  DATA_WIDTH  operand A.
- B  in  DATA_WIDTH  operand B.
- ALUop  in  4  operation code (see Operation).
- out_valid  out  1  result valid; equals (state==DONE).
- out_ready  in  1  consumer accepts result.
- Result  out  DATA_WIDTH  primary result / product low / quotient.
- ResultHi  out  DATA_WIDTH  product high / remainder; 0 for other ops.
- Overflow  out  1  see per-op rules.
- CarryOut  out  1  see per-op rules.
- Zero  out  1  Result == 0.

## Operation
- Request accepted on an edge where in_valid && in_ready. A, B and ALUop are captured; inputs are ignored otherwise.
- ALUop encodings:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed); 0011 XOR; 0100 NOR (single-cycle).
  - 1000 MULU; 1001 DIVU (multi-cycle).
  - Any other code: Result=0, ResultHi=0, Overflow=CarryOut=0, Zero=1, single-cycle.
- Flags:
  - ADD: CarryOut = carry out of MSB; Overflow = signed overflow.
  - SUB: computed as A + ~B + 1. CarryOut = unsigned borrow (A < B); Overflow = signed overflow.
  - SLT: Result = {0…, signed(A) < signed(B)}; Overflow=CarryOut=0. Must be correct even when A−B overflows.
  - Logic ops: Overflow=CarryOut=0.
  - MULU: {ResultHi, Result} = A*B (2·DATA_WIDTH bits, unsigned); Overflow = (ResultHi != 0); CarryOut=0.
  - DIVU: Result = A/B, ResultHi = A%B (restoring division); CarryOut=0; Overflow = (B==0). For B==0: Result = all ones, ResultHi = A.
- Zero = (Result == 0) for every op, ResultHi ignored.
- FSM:
  - IDLE --accept single-cycle op--> DONE.
  - IDLE --accept MULU/DIVU--> CALC. Counter cleared; operands and accumulators loaded.
  - CALC: one shift-add (MULU) or shift-subtract (DIVU) iteration per cycle. Counter increments each cycle. After DATA_WIDTH iterations, the final values are registered and the FSM goes to DONE.
  - DONE --out_ready--> IDLE; otherwise stay.
- Result, ResultHi and flags are registered outputs. They are held stable while out_valid && !out_ready, and also in IDLE until the next result. No new request is accepted before the result handshake completes.

## Timing
- Reset (resetn low, any state including mid-CALC): state=IDLE, counter=0, out_valid=0, Result=0, ResultHi=0, Overflow=0, CarryOut=0, Zero=0. Any in-flight operation is discarded.
- in_ready is high throughout reset and immediately after; no request can be accepted while resetn is low.
- Single-cycle ops: accept at edge 0 → out_valid high after edge 1 (latency 1). Peak throughput is 1 op per 2 cycles, with out_ready held high.
- MULU/DIVU: accept at edge 0. Iterations occur on edges 1..DATA_WIDTH. out_valid goes high after edge DATA_WIDTH+1 (33 for default width).
- Latency does not depend on operand values, including B==0 or A==0.
- in_valid during CALC/DONE: ignored. The requester must hold the request until in_ready.
- out_valid && out_ready at edge n → IDLE after edge n. in_ready is high in cycle n+1; the earliest next acceptance is edge n+1.

## Test plan
- SUB, A=0x80000001, B=0x00000001 → Result=0x80000000, Overflow=0, CarryOut=0, Zero=0, out_valid 1 cycle after accept. SLT with the same operands → Result=1.
- ADD 0x7FFFFFFF+0x00000001 → 0x80000000, Overflow=1, CarryOut=0. ADD 0xFFFFFFFF+0x00000001 → Result=0, CarryOut=1, Overflow=0, Zero=1.
- MULU 0xFFFFFFFF*0xFFFFFFFF → ResultHi=0xFFFFFFFE, Result=0x00000001, Overflow=1. out_valid exactly 33 cycles after accept; in_ready low during that interval.
- DIVU 100/7 → Result=14, ResultHi=2, Overflow=0. DIVU 5/0 → Result=0xFFFFFFFF, ResultHi=5, Overflow=1. Latency is 33 in both cases.
- Backpressure: out_ready low for 5 cycles after out_valid → outputs stable and in_valid ignored. out_ready high → in_ready high next cycle; a back-to-back XOR 0xF0F0F0F0^0xFFFFFFFF → 0x0F0F0F0F.
- Reset mid-MULU: resetn low at cycle 10 of CALC → all outputs 0, state IDLE. After release, ADD 2+3 → Result=5 with latency 1.
- Repeat one ADD/SUB/MULU/DIVU with DATA_WIDTH=8. MULU 0xFF*0xFF → {0xFE,0x01}, latency 9.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked single-issue execution unit: single-cycle logic/arith ops plus
// iterative unsigned multiply (shift-add) and divide (restoring shift-subtract).
module seq_alu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] ResultHi,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int unsigned W = DATA_WIDTH;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_result;
  logic [W-1:0]     r_result_hi;
  logic             r_ovf;
  logic             r_cout;
  logic             r_zero;

  logic             w_accept;
  logic             w_multi;
  logic             w_last;
  logic             w_sub;
  logic [W-1:0]     w_bop;
  logic [W:0]       w_sum;
  logic             w_sv;
  logic             w_lt;
  logic [W-1:0]     w_s_res;
  logic             w_s_ovf;
  logic             w_s_cout;
  logic [W:0]       w_madd;
  logic [W:0]       w_shift;
  logic [W-1:0]     w_diff;
  logic             w_ge;
  logic [W-1:0]     w_hi_nxt;
  logic [W-1:0]     w_lo_nxt;

  assign w_accept = in_valid && in_ready;
  assign w_multi  = (ALUop == OP_MULU) || (ALUop == OP_DIVU);
  assign w_last   = (r_cnt == CNT_W'(W - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_multi ? S_CALC : S_DONE;
      S_CALC:  if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // SUB and SLT share the A + ~B + 1 adder; SLT resolves overflow by sign comparison
  assign w_sub = (ALUop == OP_SUB) || (ALUop == OP_SLT);
  assign w_bop = w_sub ? ~B : B;
  assign w_sum = {1'b0, A} + {1'b0, w_bop} + {{W{1'b0}}, w_sub};
  assign w_sv  = (A[W-1] == w_bop[W-1]) && (w_sum[W-1] != A[W-1]);
  assign w_lt  = (A[W-1] != B[W-1]) ? A[W-1] : w_sum[W-1];

  always_comb begin
    w_s_res  = '0;
    w_s_ovf  = 1'b0;
    w_s_cout = 1'b0;
    unique case (ALUop)
      OP_AND: w_s_res = A & B;
      OP_OR:  w_s_res = A | B;
      OP_XOR: w_s_res = A ^ B;
      OP_NOR: w_s_res = ~(A | B);
      OP_ADD: begin
        w_s_res  = w_sum[W-1:0];
        w_s_cout = w_sum[W];
        w_s_ovf  = w_sv;
      end
      OP_SUB: begin
        w_s_res  = w_sum[W-1:0];
        w_s_cout = ~w_sum[W];
        w_s_ovf  = w_sv;
      end
      OP_SLT:  w_s_res = {{(W-1){1'b0}}, w_lt};
      default: w_s_res = '0;
    endcase
  end

  // One iteration: r_hi/r_lo hold product hi/lo (MULU) or remainder/dividend-quotient (DIVU)
  assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_hi, r_lo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[W-1:0] - r_b;

  always_comb begin
    if (r_div) begin
      w_hi_nxt = w_ge ? w_diff : w_shift[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], w_ge};
    end else begin
      w_hi_nxt = w_madd[W:1];
      w_lo_nxt = {w_madd[0], r_lo[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_div       <= 1'b0;
      r_b         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_ovf       <= 1'b0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_accept) begin
      if (w_multi) begin
        r_cnt <= '0;
        r_div <= (ALUop == OP_DIVU);
        r_b   <= B;
        r_hi  <= '0;
        r_lo  <= A;
      end else begin
        r_result    <= w_s_res;
        r_result_hi <= '0;
        r_ovf       <= w_s_ovf;
        r_cout      <= w_s_cout;
        r_zero      <= (w_s_res == '0);
      end
    end else if (r_state == S_CALC) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result    <= w_lo_nxt;
        r_result_hi <= w_hi_nxt;
        r_ovf       <= r_div ? (r_b == '0) : (w_hi_nxt != '0);
        r_cout      <= 1'b0;
        r_zero      <= (w_lo_nxt == '0);
      end
    end
  end

  assign Result   = r_result;
  assign ResultHi = r_result_hi;
  assign Overflow = r_ovf;
  assign CarryOut = r_cout;
  assign Zero     = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at widths 32 and 8: driver pushes model results,
// per-width monitors compare whenever out_valid is presented.
module tb_seq_alu;

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic        ovf;
    logic        cout;
    logic        zero;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv32, ir32, ov32, or32, ovf32, co32, z32;
  logic [31:0] a32, b32, r32, rh32;
  logic [3:0]  op32;
  logic        iv8, ir8, ov8, or8, ovf8, co8, z8;
  logic [7:0]  a8, b8, r8, rh8;
  logic [3:0]  op8;

  seq_alu #(.DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .resetn(resetn), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .ALUop(op32), .out_valid(ov32), .out_ready(or32), .Result(r32), .ResultHi(rh32),
    .Overflow(ovf32), .CarryOut(co32), .Zero(z32));

  seq_alu #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .ALUop(op8), .out_valid(ov8), .out_ready(or8), .Result(r8), .ResultHi(rh8),
    .Overflow(ovf8), .CarryOut(co8), .Zero(z8));

  exp_t q32[$];
  exp_t q8[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit operands
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input int unsigned w);
    exp_t e;
    logic [63:0] mask, s;
    longint sa, sb, sr, maxp, minn;
    mask = (64'd1 << w) - 64'd1;
    sa   = a[w-1] ? $signed(a | ~mask) : $signed(a);
    sb   = b[w-1] ? $signed(b | ~mask) : $signed(b);
    maxp = longint'(mask >> 1);
    minn = -maxp - 1;
    e = '{default: 0};
    e.lat = 1;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b0100: e.res = ~(a | b) & mask;
      4'b0010: begin
        s = a + b;
        e.res  = s & mask;
        e.cout = s[w];
        sr = sa + sb;
        e.ovf = (sr > maxp) || (sr < minn);
      end
      4'b0110: begin
        e.res  = (a - b) & mask;
        e.cout = (a < b);
        sr = sa - sb;
        e.ovf = (sr > maxp) || (sr < minn);
      end
      4'b0111: e.res = (sa < sb) ? 64'd1 : 64'd0;
      4'b1000: begin
        e.lat = w + 1;
        s = a * b;
        e.res = s & mask;
        e.hi  = s >> w;
        e.ovf = (e.hi != 0);
      end
      4'b1001: begin
        e.lat = w + 1;
        if (b == 0) begin
          e.res = mask;
          e.hi  = a;
          e.ovf = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
      default: ;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  exp_t m32, m8;
  bit seen32 = 0, seen8 = 0;

  always @(negedge clk) begin
    if (resetn && ov32) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out32: out_valid=1 expected=0 (cycle %0d)", cyc);
      end else begin
        m32 = q32[0];
        chk("res32", 64'(r32), m32.res);
        chk("hi32", 64'(rh32), m32.hi);
        chk("ovf32", 64'(ovf32), 64'(m32.ovf));
        chk("cout32", 64'(co32), 64'(m32.cout));
        chk("zero32", 64'(z32), 64'(m32.zero));
        if (!seen32) begin
          chk("lat32", 64'(cyc + 1 - m32.acc), 64'(m32.lat));
          seen32 = 1;
        end
        if (or32) begin q32.delete(0); seen32 = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && ov8) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out8: out_valid=1 expected=0 (cycle %0d)", cyc);
      end else begin
        m8 = q8[0];
        chk("res8", 64'(r8), m8.res);
        chk("hi8", 64'(rh8), m8.hi);
        chk("ovf8", 64'(ovf8), 64'(m8.ovf));
        chk("cout8", 64'(co8), 64'(m8.cout));
        chk("zero8", 64'(z8), 64'(m8.zero));
        if (!seen8) begin
          chk("lat8", 64'(cyc + 1 - m8.acc), 64'(m8.lat));
          seen8 = 1;
        end
        if (or8) begin q8.delete(0); seen8 = 0; end
      end
    end
  end

  // Driver runs at posedge+1; returns one cycle after the accepting edge
  task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit chk_busy, input bit rnd);
    int unsigned n = 0;
    int unsigned bad = 0;
    int unsigned w = w8 ? 8 : 32;
    logic [31:0] mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
    exp_t e;
    while (!(w8 ? ir8 : ir32) && n < 300) begin
      if (rnd) begin
        if (w8) or8 = ($urandom % 3) != 0;
        else    or32 = ($urandom % 3) != 0;
      end
      @(posedge clk); #1; n++;
    end
    chk("issue_wait_timeout", 64'(n >= 300), 64'd0);
    if (n >= 300) return;
    e = model(op, {32'd0, a & mask}, {32'd0, b & mask}, w);
    e.acc = cyc + 1;
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; op8 = op; iv8 = 1'b1; q8.push_back(e); end
    else    begin a32 = a; b32 = b; op32 = op; iv32 = 1'b1; q32.push_back(e); end
    @(posedge clk); #1;
    // Junk requests while busy must be ignored
    if (w8) begin iv8 = rnd ? 1'($urandom) : 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom); end
    else    begin iv32 = rnd ? 1'($urandom) : 1'b0; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom); end
    if (chk_busy && e.lat > 1) begin
      n = 0;
      while (!(w8 ? ov8 : ov32) && n < w + 5) begin
        if (w8 ? ir8 : ir32) bad++;
        @(posedge clk); #1; n++;
      end
      chk(w8 ? "busy_in_ready8" : "busy_in_ready32", 64'(bad), 64'd0);
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    iv32 = 1'b0; iv8 = 1'b0; or32 = 1'b1; or8 = 1'b1;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", 64'(n >= 200), 64'd0);
  endtask

  task automatic run(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(w8, op, a, b, 1'b1, 1'b0);
    drain();
  endtask

  task automatic check_reset_state();
    chk("rst_res32", 64'(r32), 64'd0);
    chk("rst_hi32", 64'(rh32), 64'd0);
    chk("rst_flags32", {61'd0, ovf32, co32, z32}, 64'd0);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    chk("rst_in_ready32", 64'(ir32), 64'd1);
    chk("rst_res8", {48'd0, r8, rh8}, 64'd0);
    chk("rst_in_ready8", 64'(ir8), 64'd1);
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] t[9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b0100, 4'b1000, 4'b1001};
    if ($urandom % 8 == 0) return 4'($urandom);
    return t[$urandom % 9];
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; or32 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; or8 = 1'b1;
    #2 resetn = 1'b0;
    #1 check_reset_state();
    // A request presented during reset must not be taken
    iv32 = 1'b1; a32 = 32'd2; b32 = 32'd3; op32 = 4'b0010;
    @(posedge clk); @(posedge clk); #1;
    iv32 = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 64'(ir32), 64'd1);

    run(0, 4'b0110, 32'h8000_0001, 32'h0000_0001);
    run(0, 4'b0111, 32'h8000_0001, 32'h0000_0001);
    run(0, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    run(0, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    run(0, 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
    run(0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(0, 4'b1001, 32'd100, 32'd7);
    run(0, 4'b1001, 32'd5, 32'd0);
    run(0, 4'b1000, 32'd0, 32'h1234_5678);
    run(0, 4'b1111, 32'h1234_5678, 32'h1);

    // Backpressure: hold out_ready low 5 cycles with junk requests, then back-to-back XOR
    or32 = 1'b0;
    issue(0, 4'b0110, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 5; k++) begin
      iv32 = 1'b1; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
      @(posedge clk); #1;
    end
    chk("bp_out_valid_held", 64'(ov32), 64'd1);
    iv32 = 1'b0; or32 = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_next", 64'(ir32), 64'd1);
    issue(0, 4'b0011, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drain();

    // Reset in the middle of a multiply
    issue(0, 4'b1000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 resetn = 1'b0;
    #1 q32.delete();
    seen32 = 0;
    check_reset_state();
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run(0, 4'b0010, 32'd2, 32'd3);

    for (int unsigned k = 0; k < 150; k++)
      issue(0, rand_op(), rand_opnd(), rand_opnd(), 1'b1, 1'b1);
    drain();

    run(1, 4'b0010, 32'h7F, 32'h01);
    run(1, 4'b0110, 32'h00, 32'h01);
    run(1, 4'b1000, 32'hFF, 32'hFF);
    run(1, 4'b1001, 32'd200, 32'd7);
    run(1, 4'b1001, 32'd9, 32'd0);
    for (int unsigned k = 0; k < 40; k++)
      issue(1, rand_op(), rand_opnd(), rand_opnd(), 1'b1, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
